anti_clarke_seq: RTL and testbench
==================================

ANTI_CLARKE_SEQ -- requirements
Module: anti_clarke_seq

Interface
REQ-001 SHALL have parameter ENABLE_SATURATION, default 1, meaning clamp b/c to the 18-bit range (0 = wrap).
REQ-002 SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-004 SHALL have port alpha  input  18  signed stationary-frame alpha, Q1.17, same scaling as the anti-Park alpha output.
REQ-005 SHALL have port beta  input  18  signed stationary-frame beta, Q1.17.
REQ-006 SHALL have port in_valid  input  1  alpha/beta are valid this cycle.
REQ-007 SHALL have port in_ready  output  1  block can accept a sample this cycle.
REQ-008 SHALL have port a  output  18  signed phase-a output, Q1.17.
REQ-009 SHALL have port b  output  18  signed phase-b output, Q1.17.
REQ-010 SHALL have port c  output  18  signed phase-c output, Q1.17.
REQ-011 SHALL have port out_valid  output  1  a/b/c hold a completed result.
REQ-012 SHALL have port out_ready  input  1  consumer takes the result this cycle.

Function
REQ-013 SHALL compute a = alpha, b = -alpha/2 + K*beta, c = -alpha/2 - K*beta, with K = sqrt(3)/2 = 113512 in Q1.17.
REQ-014 SHALL form alpha/2 by arithmetic right shift by 1 (floor), and K*beta as the 36-bit signed product arithmetically shifted right by 17 (floor).
REQ-015 SHALL evaluate b and c at 20 bits before reduction, then saturate to [-131072, 131071] when ENABLE_SATURATION=1, else keep the low 18 bits.
REQ-016 SHALL use one registered 18x18 multiplier, with the FSM states IDLE, MULT, SUM, HOLD.
REQ-017 IDLE: in_ready=1; on in_valid=1, SHALL capture alpha/beta and go to MULT.
REQ-018 MULT: SHALL register the product K*beta and go to SUM; SUM: SHALL register a/b/c and go to HOLD.
REQ-019 HOLD: out_valid=1; a/b/c SHALL stay stable until out_ready=1, then go to IDLE.
REQ-020 in_ready SHALL be 0 in MULT, SUM and HOLD; inputs offered then SHALL be ignored (no capture, no corruption).
REQ-021 Latency SHALL be 3 cycles from the accepting edge to out_valid=1 when out_ready is held at 1; maximum throughput is one sample per 4 cycles.
REQ-022 HOLD with out_ready=1 and in_valid=1 in the same cycle SHALL release the result only; the new sample is accepted in the next IDLE cycle.
REQ-023 out_ready asserted outside HOLD SHALL have no effect.
REQ-024 a, b and c SHALL change only on the transition SUM->HOLD.

Reset
REQ-025 On reset=0, regardless of clock, the block SHALL force state=IDLE, a=b=c=0, out_valid=0 and in_ready=0 while reset is held, and clear the internal registers to 0.
REQ-026 On reset release, in_ready SHALL become 1 from the first clock edge; reset during MULT, SUM or HOLD SHALL discard the in-flight sample with no out_valid pulse.

Structure
REQ-027 The shared package tau_pkg SHALL hold the constant SQRT3_OVER_2_Q17 = 113512, the width constant DATA_W = 18 and the FSM state encoding.
REQ-028 The 20-to-18-bit clamp SHALL be the sub-module sat_signed, parameterised IN_W/OUT_W, with one instance each for b and c.

Verification
REQ-029 alpha=65536, beta=0, out_ready=1 -> a=65536, b=-32768, c=-32768, out_valid=1 exactly 3 cycles after acceptance.
REQ-030 alpha=0, beta=131071 -> a=0, b=113511, c=-113511.
REQ-031 alpha=-131072, beta=131071, SAT=1 -> a=-131072, b=131071 (clamped), c=-47975; with SAT=0, b = 179047 wrapped to 18 bits = -83097.
REQ-032 alpha=-131072, beta=-131072 -> b=-47976, c=131071 (clamped).
REQ-033 Hold out_ready=0 for 10 cycles while toggling alpha/beta/in_valid -> outputs stay stable, in_ready=0 throughout; out_ready=1 -> IDLE next cycle, then the next sample is accepted.
REQ-034 Assert reset=0 asynchronously mid-SUM -> outputs 0 immediately, no out_valid; after release, a sample completes normally.

Source files
------------

// File: rtl/tau_pkg.sv
// Shared constants for the anti-Clarke transform: data widths, the
// sqrt(3)/2 coefficient in Q1.17 and the sequencer state encoding.
package tau_pkg;

  localparam int DATA_W = 18;          // sample width, signed Q1.17
  localparam int SUM_W  = 20;          // headroom for -alpha/2 +/- K*beta
  localparam int PROD_W = 2 * DATA_W;  // full 18x18 signed product
  localparam int FRAC_W = 17;          // fractional bits of Q1.17

  // sqrt(3)/2 in Q1.17; fits in an 18-bit signed value.
  localparam logic signed [DATA_W-1:0] SQRT3_OVER_2_Q17 = 18'sd113512;

  // Sequencer states: one sample walks IDLE -> MULT -> SUM -> HOLD.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MULT = 2'd1;
  localparam logic [1:0] ST_SUM  = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

endpackage

// File: rtl/sat_signed.sv
// Signed width reduction: clamps to the output range when ENABLE is
// nonzero, otherwise keeps the low OUT_W bits (two's-complement wrap).
module sat_signed #(
  parameter int IN_W   = 20,
  parameter int OUT_W  = 18,
  parameter int ENABLE = 1
) (
  input  logic signed [IN_W-1:0]  i_din,
  output logic signed [OUT_W-1:0] o_dout
);

  localparam logic signed [OUT_W-1:0] MAX_V = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] MIN_V = {1'b1, {(OUT_W-1){1'b0}}};

  logic w_fits;

  // The value fits when every dropped bit matches the kept sign bit.
  assign w_fits = (i_din[IN_W-1:OUT_W-1] == {(IN_W-OUT_W+1){i_din[IN_W-1]}});

  // Pass through, or pin to the rail on the side of the input's sign.
  always_comb begin
    o_dout = i_din[OUT_W-1:0];
    if ((ENABLE != 0) && !w_fits) begin
      o_dout = i_din[IN_W-1] ? MIN_V : MAX_V;
    end
  end

endmodule

// File: rtl/anti_clarke_seq.sv
// Sequential anti-Clarke transform: alpha/beta (Q1.17) to three phase
// values a/b/c using one registered 18x18 multiplier.
//
// Handshake: a sample is taken on a rising edge where in_valid and
// in_ready are both 1; a result is released on a rising edge where
// out_valid and out_ready are both 1. in_ready is only high in IDLE and
// out_valid only in HOLD, so a release and a new accept never share an
// edge; the next sample goes in on the following IDLE cycle.
module anti_clarke_seq
  import tau_pkg::*;
#(
  parameter int ENABLE_SATURATION = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] alpha,
  input  logic signed [DATA_W-1:0] beta,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [DATA_W-1:0] a,
  output logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] c,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               o_dbg_state
);

  logic [1:0]               r_state;
  logic                     r_run;    // low until the first edge after reset
  logic signed [DATA_W-1:0] r_alpha;
  logic signed [DATA_W-1:0] r_beta;
  logic signed [PROD_W-1:0] r_prod;
  logic signed [DATA_W-1:0] r_a;
  logic signed [DATA_W-1:0] r_b;
  logic signed [DATA_W-1:0] r_c;

  logic signed [PROD_W-1:0] w_prod;
  logic signed [SUM_W-1:0]  w_half;
  logic signed [SUM_W-1:0]  w_kb;
  logic signed [SUM_W-1:0]  w_b_full;
  logic signed [SUM_W-1:0]  w_c_full;
  logic signed [DATA_W-1:0] w_b_red;
  logic signed [DATA_W-1:0] w_c_red;
  logic                     w_accept;
  logic                     w_release;

  assign in_ready    = r_run && (r_state == ST_IDLE);
  assign out_valid   = (r_state == ST_HOLD);
  assign w_accept    = in_valid && in_ready;
  assign w_release   = out_valid && out_ready;
  assign a           = r_a;
  assign b           = r_b;
  assign c           = r_c;
  assign o_dbg_state = r_state;

  // Datapath arithmetic; both shifts are arithmetic, so they round to floor.
  assign w_prod   = PROD_W'(r_beta) * PROD_W'(SQRT3_OVER_2_Q17);
  assign w_half   = SUM_W'(r_alpha) >>> 1;
  assign w_kb     = SUM_W'(r_prod >>> FRAC_W);
  assign w_b_full = w_kb - w_half;
  assign w_c_full = SUM_W'(0) - w_half - w_kb;

  sat_signed #(.IN_W(SUM_W), .OUT_W(DATA_W), .ENABLE(ENABLE_SATURATION)) u_sat_b (
    .i_din  (w_b_full),
    .o_dout (w_b_red)
  );

  sat_signed #(.IN_W(SUM_W), .OUT_W(DATA_W), .ENABLE(ENABLE_SATURATION)) u_sat_c (
    .i_din  (w_c_full),
    .o_dout (w_c_red)
  );

  // Sequencer: one sample at a time, the result is held until it is taken.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_run   <= 1'b0;
    end else begin
      r_run <= 1'b1;
      case (r_state)
        ST_IDLE: if (w_accept)  r_state <= ST_MULT;
        ST_MULT:                r_state <= ST_SUM;
        ST_SUM:                 r_state <= ST_HOLD;
        ST_HOLD: if (w_release) r_state <= ST_IDLE;
        default:                r_state <= ST_IDLE;
      endcase
    end
  end

  // Operand capture, product register and result registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_alpha <= '0;
      r_beta  <= '0;
      r_prod  <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
    end else begin
      if (w_accept) begin
        r_alpha <= alpha;
        r_beta  <= beta;
      end
      if (r_state == ST_MULT) begin
        r_prod <= w_prod;
      end
      if (r_state == ST_SUM) begin
        r_a <= r_alpha;
        r_b <= w_b_red;
        r_c <= w_c_red;
      end
    end
  end

endmodule

// File: tb/tb_anti_clarke_seq.sv
// Bench for anti_clarke_seq: a saturating and a wrapping instance share
// the same stimulus; results are checked against an arithmetic model.
`timescale 1ns/1ps
module tb_anti_clarke_seq;

  localparam int     W  = 18;
  localparam int     EW = 5 * W;
  localparam longint K  = 113512;

  logic                clock;
  logic                reset;
  logic signed [W-1:0] alpha;
  logic signed [W-1:0] beta;
  logic                in_valid;
  logic                out_ready;
  logic                in_ready,  in_ready_w;
  logic signed [W-1:0] a, b, c;
  logic signed [W-1:0] a_w, b_w, c_w;
  logic                out_valid, out_valid_w;
  logic [1:0]          dbg_s, dbg_w;

  int n_checks = 0;
  int n_errors = 0;

  logic [EW-1:0] exp_q[$];

  anti_clarke_seq #(.ENABLE_SATURATION(1)) dut (
    .clock(clock), .reset(reset), .alpha(alpha), .beta(beta),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .c(c),
    .out_valid(out_valid), .out_ready(out_ready), .o_dbg_state(dbg_s)
  );

  anti_clarke_seq #(.ENABLE_SATURATION(0)) dut_w (
    .clock(clock), .reset(reset), .alpha(alpha), .beta(beta),
    .in_valid(in_valid), .in_ready(in_ready_w), .a(a_w), .b(b_w), .c(c_w),
    .out_valid(out_valid_w), .out_ready(out_ready), .o_dbg_state(dbg_w)
  );

  // Clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: b/c = -floor(alpha/2) +/- floor(K*beta/2^17), then clamp or wrap.
  function automatic longint model_bc(input int al, input int be, input bit is_c, input bit sat);
    longint half, kb, v;
    half = longint'(al) >>> 1;
    kb   = (K * longint'(be)) >>> 17;
    v    = is_c ? (-half - kb) : (-half + kb);
    if (sat) begin
      if (v > 131071)  v = 131071;
      if (v < -131072) v = -131072;
    end else begin
      v = v & 64'h3FFFF;
      if (v >= 131072) v = v - 262144;
    end
    return v;
  endfunction

  function automatic logic [EW-1:0] model(input int al, input int be);
    logic [W-1:0] ea, bs, cs, bw, cw;
    ea = W'(al);
    bs = W'(model_bc(al, be, 1'b0, 1'b1));
    cs = W'(model_bc(al, be, 1'b1, 1'b1));
    bw = W'(model_bc(al, be, 1'b0, 1'b0));
    cw = W'(model_bc(al, be, 1'b1, 1'b0));
    return {ea, bs, cs, bw, cw};
  endfunction

  function automatic int rnd18();
    return int'($urandom_range(0, 262143)) - 131072;
  endfunction

  task automatic drive_garbage();
    alpha     = W'(rnd18());
    beta      = W'(rnd18());
    in_valid  = 1'($urandom_range(0, 1));
    out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic check_result();
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    chk("a",      a,   longint'($signed(e[5*W-1:4*W])));
    chk("b_sat",  b,   longint'($signed(e[4*W-1:3*W])));
    chk("c_sat",  c,   longint'($signed(e[3*W-1:2*W])));
    chk("a_wrap", a_w, longint'($signed(e[5*W-1:4*W])));
    chk("b_wrap", b_w, longint'($signed(e[2*W-1:W])));
    chk("c_wrap", c_w, longint'($signed(e[W-1:0])));
  endtask

  // Driver: offer one sample, wait for the result, stall, check, release.
  task automatic send_sample(input int al, input int be, input int stall);
    int n;
    int lat;
    logic [3*W-1:0] held;
    @(negedge clock);
    alpha     = W'(al);
    beta      = W'(be);
    in_valid  = 1'b1;
    out_ready = 1'($urandom_range(0, 1));
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("in_ready_idle", in_ready, 1);
    exp_q.push_back(model(al, be));
    @(posedge clock);
    lat = 1;
    forever begin
      @(negedge clock);
      if (out_valid || lat >= 10) break;
      chk("in_ready_busy", in_ready, 0);
      drive_garbage();
      @(posedge clock);
      lat++;
    end
    out_ready = 1'b0;
    chk("latency", lat, 3);
    held = {a, b, c};
    for (int s = 0; s < stall; s++) begin
      drive_garbage();
      out_ready = 1'b0;
      @(posedge clock);
      @(negedge clock);
      chk("hold_stable", longint'({a, b, c} == held && in_ready == 1'b0 && out_valid == 1'b1), 1);
    end
    check_result();
    // Release; an in_valid offered in the same cycle must not be taken.
    drive_garbage();
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("release_idle", longint'({out_valid, in_ready, out_valid_w, in_ready_w}), 4'b0101);
  endtask

  initial begin
    int dir_a[8] = '{65536, 0, -131072, -131072, 131071, -1, 1, 131071};
    int dir_b[8] = '{0, 131071, 131071, -131072, 131071, -1, 0, -131072};

    // Reset
    reset     = 1'b0;
    alpha     = '0;
    beta      = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_in_ready",  in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_abc_zero",  longint'({a, b, c} == '0), 1);
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_held_in_ready", in_ready, 0);
    reset = 1'b1;
    #1;
    chk("rel_before_edge_in_ready", in_ready, 0);
    @(posedge clock);
    #1;
    chk("rel_after_edge_in_ready", in_ready, 1);

    // Directed corner vectors
    for (int i = 0; i < 8; i++) send_sample(dir_a[i], dir_b[i], $urandom_range(0, 2));

    // Randomized samples with random backpressure
    for (int i = 0; i < 40; i++) send_sample(rnd18(), rnd18(), $urandom_range(0, 3));

    // Long stall with toggling inputs
    send_sample(rnd18(), rnd18(), 10);

    // Asynchronous reset while the sample sits in SUM
    @(negedge clock);
    alpha    = W'(-70000);
    beta     = W'(90000);
    in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    @(posedge clock);
    #2;
    chk("pre_rst_abc_nonzero", longint'({a, b, c} != '0), 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_abc_zero",  longint'({a, b, c, a_w, b_w, c_w} == '0), 1);
    chk("mid_rst_out_valid", longint'(out_valid | out_valid_w), 0);
    chk("mid_rst_in_ready",  in_ready, 0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("mid_rst_no_valid", out_valid, 0);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("post_rst_no_valid", out_valid, 0);
    send_sample(-131072, 131071, 1);
    send_sample(rnd18(), rnd18(), 0);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
